// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB3 requester
// Contents: FSM state enum, APB data width, slot-index width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_DATA_W = 32;

    // Width of a binary index able to name every peripheral slot (at least 1 bit).
    function automatic int slot_sel_w(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_master_decode.sv
// rtl/apb_master_decode.sv - peripheral select decode: 2-bit select -> one-hot PSEL + error flag
// Ports:
//   sel_i      in   2        top address bits of the command
//   psel_o     out  NUM_SLV  one-hot select (all zero on decode error)
//   dec_err_o  out  1        select names a slot that does not exist
module apb_master_decode #(
    parameter int NUM_SLV = 4
) (
    input  logic [1:0]         sel_i,
    output logic [NUM_SLV-1:0] psel_o,
    output logic               dec_err_o
);

    always_comb begin
        psel_o = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_i == 2'(i)) begin
                psel_o[i] = 1'b1;
            end
        end
    end

    assign dec_err_o = ({30'd0, sel_i} >= 32'(NUM_SLV));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB3 requester: single-outstanding command -> SETUP/ACCESS with timeout
// Ports:
//   PCLK, PRESET                   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   rsp_valid/rsp_rdata/rsp_err    one-cycle completion pulse
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA  APB requester outputs (registered)
//   PRDATA/PREADY/PSLVERR          per-peripheral completer inputs, slot i at [32i+31:32i]
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [APB_DATA_W-1:0]         cmd_wdata,
    output logic                          rsp_valid,
    output logic [APB_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_W-1:0]             PADDR,
    output logic [NUM_SLV-1:0]            PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [APB_DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*APB_DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]            PREADY,
    input  logic [NUM_SLV-1:0]            PSLVERR
);

    localparam int SEL_W = slot_sel_w(NUM_SLV);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    apb_state_e                state_q, state_d;
    logic [ADDR_W-1:0]         paddr_q, paddr_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [NUM_SLV-1:0]        psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic [SEL_W-1:0]          slot_q, slot_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

    logic [NUM_SLV-1:0]        dec_psel;
    logic                      dec_err;
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_W-1:0]     sel_rdata;

    apb_master_decode #(
        .NUM_SLV (NUM_SLV)
    ) u_decode (
        .sel_i     (cmd_addr[ADDR_W-1:ADDR_W-2]),
        .psel_o    (dec_psel),
        .dec_err_o (dec_err)
    );

    // Only the slot latched at accept time is observed; other completers may be busy
    // with nothing or driving garbage.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slot_q == SEL_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (dec_err) begin
                        // Nonexistent peripheral: answer immediately without touching the bus.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        pwdata_d = cmd_wdata;
                        psel_d   = dec_psel;
                        slot_d   = SEL_W'(cmd_addr[ADDR_W-1:ADDR_W-2]);
                        state_d  = SETUP;
                    end
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end

            ACCESS: begin
                // PREADY is tested first so a completion in the timeout cycle still succeeds.
                if (sel_ready) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            slot_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with scoreboarded responses
`timescale 1ns/1ps
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Main instance: 4 slots, TIMEOUT 16
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  PADDR;
    logic [3:0]  PSEL;
    logic        PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [127:0] PRDATA;
    logic [3:0]  PREADY, PSLVERR;

    apb_master #(.ADDR_W(8), .NUM_SLV(4), .TIMEOUT(16)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Three-slot instance for decode errors
    logic        cmd3_valid, cmd3_ready, cmd3_write;
    logic [7:0]  cmd3_addr;
    logic [31:0] cmd3_wdata;
    logic        rsp3_valid, rsp3_err;
    logic [31:0] rsp3_rdata;
    logic [7:0]  PADDR3;
    logic [2:0]  PSEL3;
    logic        PENABLE3, PWRITE3;
    logic [31:0] PWDATA3;
    logic [95:0] PRDATA3;
    logic [2:0]  PREADY3, PSLVERR3;

    assign PRDATA3  = {32'hA5A5A502, 32'hA5A5A501, 32'hA5A5A500};
    assign PREADY3  = 3'b111;
    assign PSLVERR3 = 3'b000;

    apb_master #(.ADDR_W(8), .NUM_SLV(3), .TIMEOUT(16)) u_dut3 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready), .cmd_write(cmd3_write),
        .cmd_addr(cmd3_addr), .cmd_wdata(cmd3_wdata),
        .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata), .rsp_err(rsp3_err),
        .PADDR(PADDR3), .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3), .PWDATA(PWDATA3),
        .PRDATA(PRDATA3), .PREADY(PREADY3), .PSLVERR(PSLVERR3)
    );

    // Completer models: slot0 zero-wait with error at 0x08, slot1 registered PREADY,
    // slot2 never ready, slot3 zero-wait constant.
    logic [31:0] mem0 [4];
    logic [31:0] mem1 [4];
    logic        rdy1_q;

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
    end

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) rdy1_q <= 1'b0;
        else        rdy1_q <= PSEL[1] & PENABLE & ~rdy1_q;
    end

    always @(posedge PCLK) begin
        if (PSEL[0] && PENABLE && PWRITE) mem0[PADDR[3:2]] <= PWDATA;
        if (PSEL[1] && PENABLE && rdy1_q && PWRITE) mem1[PADDR[3:2]] <= PWDATA;
    end

    assign PREADY  = {1'b1, 1'b0, rdy1_q, 1'b1};
    assign PSLVERR = {3'b000, (PADDR == 8'h08)};
    assign PRDATA  = {32'hDEAD0003, 32'hDEAD0002, mem1[PADDR[3:2]], mem0[PADDR[3:2]]};

    // Checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];
    int   last_acc = 0;

    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input int lat, input logic e, input logic [31:0] rd);
        int   n;
        exp_t x;
        n = 0;
        @(negedge PCLK);
        while (!cmd_ready && n < 60) begin
            @(negedge PCLK);
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        last_acc  = cyc;
        x.err = e; x.rdata = rd; x.acc = cyc; x.lat = lat;
        exp_q.push_back(x);
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        cmd3_valid = 0; cmd3_write = 0; cmd3_addr = '0; cmd3_wdata = '0;

        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(rsp_err),   64'd0);
        check("rst_psel",      64'(PSEL),      64'd0);
        check("rst_penable",   64'(PENABLE),   64'd0);
        check("rst_pwrite",    64'(PWRITE),    64'd0);
        check("rst_paddr",     64'(PADDR),     64'd0);
        check("rst_pwdata",    64'(PWDATA),    64'd0);

        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        // Zero-wait write with phase checks
        send(1'b1, 8'h00, 32'hDEADBEEF, 3, 1'b0, 32'h0);
        cmd_valid = 0;
        @(negedge PCLK);
        check("w0_c1_psel",    64'(PSEL),    64'h1);
        check("w0_c1_penable", 64'(PENABLE), 64'd0);
        check("w0_c1_pwrite",  64'(PWRITE),  64'd1);
        check("w0_c1_paddr",   64'(PADDR),   64'h00);
        check("w0_c1_pwdata",  64'(PWDATA),  64'hDEADBEEF);
        check("w0_c1_ready",   64'(cmd_ready), 64'd0);
        @(negedge PCLK);
        check("w0_c2_psel",    64'(PSEL),    64'h1);
        check("w0_c2_penable", 64'(PENABLE), 64'd1);
        @(negedge PCLK);
        check("w0_c3_psel",    64'(PSEL),    64'h0);
        check("w0_c3_penable", 64'(PENABLE), 64'd0);
        check("w0_c3_ready",   64'(cmd_ready), 64'd1);
        wait_idle();

        // Registered-PREADY peripheral: write then read back
        send(1'b1, 8'h44, 32'h12345678, 4, 1'b0, 32'h0);
        cmd_valid = 0;
        wait_idle();
        send(1'b0, 8'h44, 32'h0, 4, 1'b0, 32'h12345678);
        cmd_valid = 0;
        @(negedge PCLK);
        check("r44_psel",   64'(PSEL),   64'h2);
        check("r44_pwrite", 64'(PWRITE), 64'd0);
        wait_idle();
        @(negedge PCLK);
        check("idle_hold_paddr",  64'(PADDR),  64'h44);
        check("idle_hold_pwrite", 64'(PWRITE), 64'd0);

        // Timeout: 16 ACCESS cycles starting at cycle 2
        send(1'b0, 8'h80, 32'h0, 18, 1'b1, 32'h0);
        cmd_valid = 0;
        wait_idle();
        check("to_psel",    64'(PSEL),    64'h0);
        check("to_penable", 64'(PENABLE), 64'd0);

        // Back-to-back writes, second gets PSLVERR
        send(1'b1, 8'h04, 32'h11111111, 3, 1'b0, 32'h0);
        a1 = last_acc;
        send(1'b1, 8'h08, 32'h22222222, 3, 1'b1, 32'h0);
        cmd_valid = 0;
        check("b2b_spacing", 64'(last_acc - a1), 64'd3);
        @(negedge PCLK);
        check("b2b_setup_psel",    64'(PSEL),    64'h1);
        check("b2b_setup_penable", 64'(PENABLE), 64'd0);
        check("b2b_setup_paddr",   64'(PADDR),   64'h08);
        wait_idle();
        send(1'b0, 8'h04, 32'h0, 3, 1'b0, 32'h11111111);
        cmd_valid = 0;
        wait_idle();
        send(1'b0, 8'h08, 32'h0, 3, 1'b1, 32'h0);
        cmd_valid = 0;
        wait_idle();

        // Reset during ACCESS
        send(1'b0, 8'h80, 32'h0, 18, 1'b1, 32'h0);
        cmd_valid = 0;
        repeat (2) @(negedge PCLK);
        check("rst_mid_access", 64'(PENABLE), 64'd1);
        #2;
        PRESET = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_psel",    64'(PSEL),      64'h0);
        check("rst_mid_penable", 64'(PENABLE),   64'd0);
        check("rst_mid_rsp",     64'(rsp_valid), 64'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (25) @(negedge PCLK);
        check("rst_after_ready", 64'(cmd_ready), 64'd1);
        send(1'b1, 8'h0C, 32'hCAFEF00D, 3, 1'b0, 32'h0);
        cmd_valid = 0;
        wait_idle();

        // Three-slot instance: decode error then a valid slot-2 read
        @(negedge PCLK);
        cmd3_valid = 1; cmd3_write = 0; cmd3_addr = 8'hC0;
        @(posedge PCLK);
        #1;
        cmd3_valid = 0;
        @(negedge PCLK);
        check("dec_rsp_valid", 64'(rsp3_valid), 64'd1);
        check("dec_rsp_err",   64'(rsp3_err),   64'd1);
        check("dec_rsp_rdata", 64'(rsp3_rdata), 64'd0);
        check("dec_psel",      64'(PSEL3),      64'h0);
        check("dec_ready",     64'(cmd3_ready), 64'd1);
        @(negedge PCLK);
        check("dec_pulse_end", 64'(rsp3_valid), 64'd0);
        cmd3_valid = 1; cmd3_write = 0; cmd3_addr = 8'h80;
        @(posedge PCLK);
        #1;
        cmd3_valid = 0;
        @(negedge PCLK);
        check("s3_psel", 64'(PSEL3), 64'h4);
        @(negedge PCLK);
        @(negedge PCLK);
        check("s3_rsp_valid", 64'(rsp3_valid), 64'd1);
        check("s3_rsp_err",   64'(rsp3_err),   64'd0);
        check("s3_rsp_rdata", 64'(rsp3_rdata), 64'hA5A5A502);

        repeat (3) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB3 requester that converts a simple single-outstanding command interface into APB SETUP/ACCESS transfers toward up to four memory-mapped peripherals sharing one bus. It decodes a one-hot PSEL from the top address bits, tolerates any number of PREADY wait states, and bounds every access with a timeout. It sits between a CPU/testbench command source and the existing 4-register APB peripherals.

## Interface
- ADDR_W, 8: command and PADDR width; bits [ADDR_W-1:ADDR_W-2] select the peripheral, bits [3:0] are the register offset.
- NUM_SLV, 4: number of peripherals (1..4); selects >= NUM_SLV are decode errors.
- TIMEOUT, 16: maximum ACCESS cycles before forced error completion (>= 2).
- PCLK  in  1  clock.
- PRESET  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid && ready at PCLK edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  PSLVERR, timeout, or decode error.
- PADDR  out  ADDR_W  APB address (full command address).
- PSEL  out  NUM_SLV  one-hot peripheral select.
- PENABLE  out  1  ACCESS phase.
- PWRITE  out  1  direction.
- PWDATA  out  32  write data.
- PRDATA  in  NUM_SLV*32  per-peripheral read data, slot i = bits [32i+31:32i].
- PREADY  in  NUM_SLV  per-peripheral ready.
- PSLVERR  in  NUM_SLV  per-peripheral error; tie 0 where unsupported.

## Operation
- FSM states IDLE, SETUP, ACCESS. Reset -> IDLE.
- cmd_ready = (state == IDLE), combinational from state only.
- IDLE + accept, valid select: latch PADDR/PWRITE/PWDATA, PSEL one-hot, -> SETUP.
- IDLE + accept, select >= NUM_SLV: no bus activity; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay IDLE.
- SETUP: PSEL set, PENABLE=0; unconditionally -> ACCESS.
- ACCESS: PENABLE=1; only the selected slot's PREADY/PSLVERR/PRDATA are observed.
  - PREADY=1: -> IDLE; next cycle rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA slot if read && !PSLVERR, else 0. PSEL and PENABLE drop to 0.
  - PREADY=0: wait counter +1; when counter reaches TIMEOUT-1 with PREADY still 0 -> IDLE, rsp_err=1, rsp_rdata=0.
- Counter cleared on entering ACCESS; width $clog2(TIMEOUT)+1, no wrap.
- PADDR/PWRITE/PWDATA hold their values in IDLE (no toggling between transfers).
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, counter=0.
- Zero-wait transfer: accept in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. Each PREADY-low cycle adds one cycle.
- The team's peripherals register PREADY, so one wait state is inserted: rsp_valid arrives in cycle 4.
- In the rsp_valid cycle cmd_ready=1; back-to-back accept there gives SETUP in the next cycle. Minimum transfer period is 3 cycles.
- All outputs are registered except cmd_ready.
- PRESET mid-transfer: bus outputs return to reset values immediately (asynchronous); no response is issued; the command is lost.
- PREADY and timeout in the same cycle: PREADY wins (normal completion).

## Structure
- Package apb_pkg: state enum typedef (IDLE/SETUP/ACCESS), APB_DATA_W=32 constant, and slot-select width localparam function.
- Sub-module apb_master_decode: combinational address -> one-hot PSEL plus decode-error flag. The FSM, counter, and response registers live in apb_master.

## Test plan
- Write 0x00 <= 0xDEADBEEF, zero-wait slave model: PSEL[0] high cycles 1-2, PENABLE cycle 2 only, rsp_valid cycle 3 with rsp_err=0.
- Read 0x44 against a registered-PREADY 4-register peripheral previously written 0x12345678: one wait state, rsp_valid cycle 4, rsp_rdata=0x12345678, PSEL=4'b0010.
- Slave holds PREADY=0, TIMEOUT=16: rsp_valid with rsp_err=1 and rsp_rdata=0 exactly 16 ACCESS cycles after the first ACCESS cycle; PSEL returns to 0.
- NUM_SLV=3, read 0xC0: PSEL stays 0, rsp_valid next cycle with rsp_err=1.
- Back-to-back writes 0x04 then 0x08 with cmd_valid held: second SETUP begins the cycle after the first rsp_valid; PSLVERR=1 on the second -> rsp_err=1, rsp_rdata=0.
- PRESET asserted during ACCESS: PSEL/PENABLE go to 0 the same cycle, no rsp_valid, cmd_ready=1 after release.
